// File: rtl/output_argmax.sv
// rtl/output_argmax.sv - serial argmax over the MLP output activations
// Snapshots the vector on argmax_go, scans one element per clock, reports winner, value and margin.
module output_argmax #(
  parameter int WIDTH      = 8,
  parameter int OL_neurons = 10,
  parameter int IDX_W      = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          argmax_go,
  input  logic [5*WIDTH*OL_neurons-1:0] output_activations,
  output logic                          busy,
  output logic                          argmax_done,
  output logic [IDX_W-1:0]              digit,
  output logic [5*WIDTH-1:0]            max_activation,
  output logic [5*WIDTH:0]              margin,
  output logic                          result_valid
);

  localparam int AW = 5 * WIDTH;
  localparam int VW = AW * OL_neurons;
  localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(OL_neurons - 1);
  localparam logic signed [AW-1:0] MOST_NEG = {1'b1, {(AW-1){1'b0}}};

  typedef enum logic {IDLE, SCAN} state_t;

  state_t               state_q, state_d;
  logic [VW-1:0]        snap_q, snap_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [IDX_W-1:0]     best_idx_q, best_idx_d;
  logic signed [AW-1:0] best_q, best_d;
  logic signed [AW-1:0] second_q, second_d;
  logic [IDX_W-1:0]     digit_q, digit_d;
  logic [AW-1:0]        max_q, max_d;
  logic [AW:0]          margin_q, margin_d;
  logic                 done_q, done_d;
  logic                 valid_q, valid_d;

  logic signed [AW-1:0] elem;
  logic signed [AW-1:0] nbest, nsecond;
  logic [IDX_W-1:0]     nbest_idx;

  assign elem = snap_q[int'(idx_q) * AW +: AW];

  // One comparison step; strict '>' keeps the lower index on ties while the tie still lands in second.
  always_comb begin
    nbest     = best_q;
    nsecond   = second_q;
    nbest_idx = best_idx_q;
    if (idx_q == '0) begin
      nbest     = elem;
      nbest_idx = '0;
      nsecond   = MOST_NEG;
    end else if (elem > best_q) begin
      nsecond   = best_q;
      nbest     = elem;
      nbest_idx = idx_q;
    end else if (elem > second_q) begin
      nsecond   = elem;
    end
  end

  always_comb begin
    state_d    = state_q;
    snap_d     = snap_q;
    idx_d      = idx_q;
    best_idx_d = best_idx_q;
    best_d     = best_q;
    second_d   = second_q;
    digit_d    = digit_q;
    max_d      = max_q;
    margin_d   = margin_q;
    done_d     = 1'b0;
    valid_d    = valid_q;
    case (state_q)
      IDLE: begin
        if (argmax_go) begin
          snap_d  = output_activations;
          idx_d   = '0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        best_d     = nbest;
        second_d   = nsecond;
        best_idx_d = nbest_idx;
        if (idx_q == LAST_IDX) begin
          digit_d  = nbest_idx;
          max_d    = nbest;
          // One extra bit so the difference of two signed values can never wrap.
          margin_d = {nbest[AW-1], nbest} - {nsecond[AW-1], nsecond};
          done_d   = 1'b1;
          valid_d  = 1'b1;
          state_d  = IDLE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      snap_q     <= '0;
      idx_q      <= '0;
      best_idx_q <= '0;
      best_q     <= '0;
      second_q   <= '0;
      digit_q    <= '0;
      max_q      <= '0;
      margin_q   <= '0;
      done_q     <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      snap_q     <= snap_d;
      idx_q      <= idx_d;
      best_idx_q <= best_idx_d;
      best_q     <= best_d;
      second_q   <= second_d;
      digit_q    <= digit_d;
      max_q      <= max_d;
      margin_q   <= margin_d;
      done_q     <= done_d;
      valid_q    <= valid_d;
    end
  end

  assign busy           = (state_q == SCAN);
  assign argmax_done    = done_q;
  assign digit          = digit_q;
  assign max_activation = max_q;
  assign margin         = margin_q;
  assign result_valid   = valid_q;

endmodule

// File: tb/tb_output_argmax.sv
// tb/tb_output_argmax.sv - randomized and directed bench for output_argmax
// Reference model computes the winner from the whole snapshot with plain loops.
module tb_output_argmax;

  localparam int N     = 10;
  localparam int IDX_W = 4;
  localparam int AW    = 40;
  localparam longint MIN_V = -(longint'(1) <<< 39);

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            argmax_go = 1'b0;
  logic [AW*N-1:0] vec = '0;
  logic            busy, argmax_done, result_valid;
  logic [IDX_W-1:0] digit;
  logic [AW-1:0]   max_activation;
  logic [AW:0]     margin;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int t_go     = 0;

  longint m_snap[N];
  bit     m_busy = 0, m_done = 0, m_valid = 0;
  int     m_cnt = 0, m_digit = 0;
  longint m_max = 0, m_margin = 0;

  output_argmax #(.WIDTH(8), .OL_neurons(N), .IDX_W(IDX_W)) dut (
    .clk(clk), .reset(reset), .argmax_go(argmax_go), .output_activations(vec),
    .busy(busy), .argmax_done(argmax_done), .digit(digit),
    .max_activation(max_activation), .margin(margin), .result_valid(result_valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic longint elem_of(input logic [AW*N-1:0] v, input int i);
    logic [AW-1:0] e;
    e = v[i*AW +: AW];
    return longint'(signed'(e));
  endfunction

  task automatic set_elem(input int i, input longint val);
    vec[i*AW +: AW] = val[AW-1:0];
  endtask

  // Winner = first maximum; runner-up = largest of every other element.
  task automatic argmax_ref(input longint v[N], output int d, output longint mx, output longint mg);
    longint sec;
    d = 0;
    for (int i = 1; i < N; i++) if (v[i] > v[d]) d = i;
    sec = MIN_V;
    for (int i = 0; i < N; i++) if (i != d && v[i] > sec) sec = v[i];
    mx = v[d];
    mg = v[d] - sec;
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_busy = 0; m_done = 0; m_valid = 0; m_cnt = 0;
      m_digit = 0; m_max = 0; m_margin = 0;
    end else begin
      m_done = 0;
      if (m_busy) begin
        m_cnt++;
        if (m_cnt == N) begin
          argmax_ref(m_snap, m_digit, m_max, m_margin);
          m_busy = 0; m_done = 1; m_valid = 1;
        end
      end else if (argmax_go) begin
        for (int i = 0; i < N; i++) m_snap[i] = elem_of(vec, i);
        m_busy = 1; m_cnt = 0;
      end
    end
  end

  always @(negedge clk) begin
    chk("busy", busy, m_busy);
    chk("done", argmax_done, m_done);
    chk("valid", result_valid, m_valid);
    chk("digit", digit, m_digit);
    chk("max", longint'(signed'(max_activation)), m_max);
    chk("margin", longint'(margin), m_margin);
  end

  task automatic start_go();
    @(negedge clk);
    argmax_go = 1'b1;
    t_go = cyc;
    @(negedge clk);
    argmax_go = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    int k = 0;
    while (!argmax_done && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (!argmax_done) chk("done_timeout", 0, 1);
    lat = cyc - t_go - 1;
  endtask

  task automatic expect_result(input string nm, input int ed, input longint em, input longint eg);
    chk({nm, "_digit"}, digit, ed);
    chk({nm, "_max"}, longint'(signed'(max_activation)), em);
    chk({nm, "_margin"}, longint'(margin), eg);
    chk({nm, "_valid"}, result_valid, 1);
  endtask

  task automatic expect_zero(input string nm);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_done"}, argmax_done, 0);
    chk({nm, "_valid"}, result_valid, 0);
    chk({nm, "_digit"}, digit, 0);
    chk({nm, "_max"}, longint'(max_activation), 0);
    chk({nm, "_margin"}, longint'(margin), 0);
  endtask

  initial begin
    int lat, t1, k;
    logic [IDX_W-1:0] hold_digit;
    logic [AW-1:0]    hold_max;
    logic [AW:0]      hold_margin;

    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    expect_zero("reset");
    reset = 1'b1;
    repeat (6) @(negedge clk);
    expect_zero("idle");

    for (int i = 0; i < N; i++) set_elem(i, 10 * i);
    set_elem(7, 500);
    start_go();
    chk("busy_after_go", busy, 1);
    wait_done(lat);
    chk("t1_latency", lat, 10);
    expect_result("t1", 7, 500, 410);
    @(negedge clk);
    chk("t1_done_pulse", argmax_done, 0);

    for (int i = 0; i < N; i++) set_elem(i, -5);
    set_elem(3, 1000);
    set_elem(8, 1000);
    start_go();
    wait_done(lat);
    chk("tie_latency", lat, 10);
    expect_result("tie", 3, 1000, 0);

    for (int i = 0; i < N; i++) set_elem(i, -100);
    set_elem(5, -1);
    set_elem(0, MIN_V);
    start_go();
    wait_done(lat);
    expect_result("neg", 5, -1, 99);

    // Go re-pulsed mid-scan together with a new vector must be ignored.
    for (int i = 0; i < N; i++) set_elem(i, i);
    set_elem(4, 77);
    start_go();
    repeat (3) @(negedge clk);
    argmax_go = 1'b1;
    set_elem(9, 5000);
    @(negedge clk);
    argmax_go = 1'b0;
    wait_done(lat);
    chk("ignore_latency", lat, 10);
    expect_result("ignore", 4, 77, 68);

    // Go accepted in the done cycle; second done follows 11 cycles later.
    t1 = cyc;
    hold_digit = digit; hold_max = max_activation; hold_margin = margin;
    for (int i = 0; i < N; i++) set_elem(i, -i);
    set_elem(9, 3);
    argmax_go = 1'b1;
    t_go = cyc;
    @(negedge clk);
    argmax_go = 1'b0;
    k = 0;
    while (!argmax_done && k < 40) begin
      chk("hold_digit", digit, hold_digit);
      chk("hold_max", longint'(max_activation), longint'(hold_max));
      chk("hold_margin", longint'(margin), longint'(hold_margin));
      @(negedge clk);
      k++;
    end
    if (!argmax_done) chk("b2b_timeout", 0, 1);
    chk("b2b_gap", cyc - t1, 11);
    expect_result("b2b", 9, 3, 3);

    // Reset mid-scan aborts the run.
    for (int i = 0; i < N; i++) set_elem(i, 20);
    start_go();
    repeat (4) @(negedge clk);
    @(posedge clk);
    #2 reset = 1'b0;
    #1 expect_zero("abort");
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (12) @(negedge clk);
    chk("abort_no_done_valid", result_valid, 0);
    for (int i = 0; i < N; i++) set_elem(i, 30 - i);
    set_elem(2, 900);
    start_go();
    wait_done(lat);
    chk("post_reset_latency", lat, 10);
    expect_result("post_reset", 2, 900, 870);

    for (int r = 0; r < 16; r++) begin
      for (int i = 0; i < N; i++) begin
        logic [63:0] raw;
        raw = {$urandom, $urandom};
        if (r % 2 == 0) set_elem(i, longint'($urandom_range(0, 6)) - 3);
        else set_elem(i, longint'(signed'(raw[AW-1:0])));
      end
      if (r == 5) for (int i = 0; i < N; i++) set_elem(i, MIN_V);
      start_go();
      wait_done(lat);
      chk("rand_latency", lat, 10);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/output_argmax.md
Name: output_argmax

Overview:
- Consumer of the MLP result vector: on the MLP completion pulse, snapshots the OL_neurons signed output activations and scans them serially, one per clock.
- Reports the winning digit index, the winning activation, and the margin between the best and second-best activations, then pulses done.
- Sits directly downstream of the MLP: argmax_go connects to MLP_done, output_activations connects to output_activations. Results feed display/UART logic.

Parameters:
- WIDTH, 8, base bit width; each activation is 5*WIDTH bits, signed two's complement.
- OL_neurons, 10, number of activations; must be >= 2.
- IDX_W, 4, width of the digit index; must satisfy 2^IDX_W >= OL_neurons.

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  asynchronous, active-low reset.
- argmax_go  input  1  start strobe; sampled only in IDLE.
- output_activations  input  5*WIDTH*OL_neurons  activation vector; element i = bits [5*WIDTH*i +: 5*WIDTH], element 0 at LSBs.
- busy  output  1  high while a scan is in progress.
- argmax_done  output  1  one-cycle pulse when results update.
- digit  output  IDX_W  index of the maximum activation.
- max_activation  output  5*WIDTH  signed value of the maximum activation.
- margin  output  5*WIDTH+1  unsigned value of best minus second-best.
- result_valid  output  1  sticky; set at the first completion, cleared only by reset.

Behaviour:
- Reset (reset=0, asynchronous):
  - FSM goes to IDLE; snapshot, index and best/second registers cleared.
  - All outputs are 0.
- FSM states IDLE, SCAN.
- IDLE: argmax_go=1 sampled at edge E0:
  - Register the full output_activations vector into the snapshot.
  - idx <= 0, go to SCAN, busy <= 1.
  - Later input changes do not affect this run.
- SCAN: edge Ek (k = 1..OL_neurons) processes snapshot element k-1.
  - k=1: best <= elem0, best_idx <= 0, second <= most-negative value (-2^(5*WIDTH-1)).
  - k>1, elem > best (signed, strict): second <= best; best <= elem; best_idx <= k-1.
  - k>1, elem <= best: if elem > second, second <= elem.
  - Ties keep the lower index. A tied element still becomes second, so margin = 0.
- Completion at edge E(OL_neurons), which includes the last element's comparison:
  - digit, max_activation and margin are registered.
  - argmax_done = 1 for exactly one cycle; result_valid <= 1; busy <= 0; return to IDLE.
  - Latency: done is high in the cycle after edge OL_neurons counted from the go-sampling edge (10 cycles at the default).
- margin = sign-extend(best) - sign-extend(second), computed in 5*WIDTH+1 bits. It is always >= 0 and never overflows.
- digit, max_activation and margin hold their values until the next completion. They do not change during a scan.
- argmax_go while busy is ignored: no restart and no queueing.
- argmax_go during the argmax_done cycle is accepted, because the FSM is already in IDLE. Back-to-back runs therefore take OL_neurons+1 cycles each.
- Reset asserted mid-scan aborts the run:
  - No done pulse; outputs return to 0; result_valid returns to 0.
  - After reset is released, the next argmax_go behaves normally.
- No combinational path from inputs to outputs.

Test Plan:
- Reset held, then released with no go -> all outputs 0 and busy=0 indefinitely.
- elem[i]=10*i, except elem7=500; go pulsed one cycle -> busy for 10 cycles; argmax_done high for exactly one cycle at cycle 10 after go; digit=7, max_activation=500, margin=410, result_valid=1.
- elem3=elem8=1000, all others -5 -> digit=3, max_activation=1000, margin=0.
- All negative: elem[i]=-100 except elem5=-1 and elem0=-2^39 -> digit=5, max_activation=-1, margin=99. This confirms the comparison is signed.
- Three go-timing checks:
  - Go re-pulsed at cycle 4 of a scan while the input vector is changed -> ignored; result matches the original snapshot.
  - Go asserted in the argmax_done cycle -> second run starts; second done exactly 11 cycles after the first.
  - Outputs unchanged between the two done pulses.
- reset driven low at cycle 5 of a scan -> outputs 0 immediately (asynchronously); no argmax_done; after release a new go with elem2 maximal -> digit=2 after 10 cycles.
